in_event_ctrl: RTL and testbench
================================

Name: in_event_ctrl

Overview:
- Input-event controller for the CPU input path. Turns N raw level inputs (switches/buttons) into single rising-edge events.
- Keeps one pending flag per channel and serialises events to the CPU with round-robin arbitration.
- Each event is presented as a channel ID on a valid/ready handshake.
- Sits between the board I/O pins and the CPU IN-port logic.

Parameters:
- N, 4, number of input channels (2..16).
- IDW, $clog2(N), width of the event ID.
- DEB_CYCLES, 4, debounce stability length in cycles. Used only with IN_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  N  raw input levels, one bit per channel.
- ev_valid  output  1  an event is offered.
- ev_ready  input  1  the consumer accepts the event.
- ev_id  output  IDW  channel number of the offered event.
- pending  output  N  queued events not yet offered.
- overrun  output  N  sticky flag: an event was lost on that channel.
- clr_overrun  input  1  clears all overrun bits.

Behaviour:
- Reset (async, rst_n=0):
  - Edge stages, pending, overrun, ev_valid and ev_id all go to 0.
  - Round-robin pointer goes to N-1, so channel 0 has first priority.
  - State goes to IDLE.
  - ev_valid drops immediately, including mid-offer.
- Edge detect, per channel:
  - s1<=in[i]; s2<=s1; edge[i]=s1&~s2.
  - An input held high through reset release produces exactly one event.
  - Holding an input high never produces a second event.
- Latency: in[i] first sampled high at edge t -> pending[i]=1 after edge t+1 -> ev_valid=1, ev_id=i after edge t+2 (when idle and no competitor).
- State machine:
  - IDLE: if pending!=0, at the next edge grant a winner, load ev_id, clear that pending bit, set ev_valid, go to OFFER.
  - OFFER: ev_valid=1. ev_id and ev_valid are held stable while ev_ready=0.
  - OFFER on handshake (ev_valid&ev_ready at an edge):
    - If pending!=0 (registered value), grant the next winner in the same edge and stay in OFFER. Throughput is one event per cycle.
    - Otherwise drop ev_valid and go to IDLE.
- Arbitration:
  - Search starts at pointer+1, modulo N. The first set pending bit wins.
  - The pointer updates to the winner on each grant.
- Pending update priority, per channel, same edge:
  - Grant clears the bit, but an edge in the same cycle keeps it set (new event, no overrun).
  - Edge while the bit is set and not granted -> overrun[i]<=1, bit stays 1.
  - The channel currently in ev_id is not pending, so a new edge on it pends normally.
- overrun:
  - clr_overrun clears all bits.
  - A new overrun in the same cycle wins; that bit stays 1.
- No arithmetic beyond the pointer increment modulo N. When N is not a power of 2, the increment wraps explicitly from N-1 to 0.

Optional Feature:
- Macro IN_DEBOUNCE_EN.
- Defined:
  - Each channel has a counter and a filtered level f[i].
  - The counter counts consecutive cycles where in[i]!=f[i] and resets to 0 when they are equal.
  - When the count reaches DEB_CYCLES, f[i] toggles and the counter clears.
  - Edge detection runs on f[i] instead of in[i], adding DEB_CYCLES cycles of latency.
  - Pulses shorter than DEB_CYCLES are ignored.
  - f and the counters reset to 0.
- Undefined: no counters; edge detection samples in[i] directly, with the latency given above.

Decomposition:
- Package in_event_pkg:
  - State enum {IDLE, OFFER}.
  - Default N and DEB_CYCLES constants.
  - ID-width helper function.
- Sub-module edge_rise_det: one channel, containing the two-flop edge detector plus the optional debounce filter. Instantiated N times in a generate loop.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. Reset with in=0 -> all outputs 0. Then in=4'b0001 from edge 0, held high, ev_ready=1 -> ev_valid=1, ev_id=0 after edge 2, valid for one cycle only; no further events.
2. in 0->4'b1111 in one cycle, ev_ready=1 -> ev_id 0,1,2,3 on four consecutive cycles, then ev_valid=0 and pending=0.
3. ev_ready=0, three separated rising pulses on ch2 -> ev_id=2 held stable, pending[2]=1, overrun=4'b0100. Assert ev_ready -> second ch2 event delivered, pending=0.
4. ch0 and ch1 toggling every 2 cycles, ev_ready=1 -> grants alternate 0,1,0,1; no channel is granted twice in a row while the other is pending.
5. clr_overrun=1 in the same cycle as a new ch3 overrun -> overrun[3] stays 1. A clr_overrun pulse alone the next cycle -> overrun=0.
6. rst_n low mid-OFFER -> ev_valid=0 immediately. With IN_DEBOUNCE_EN and DEB_CYCLES=4, a 3-cycle high glitch gives no event; a 6-cycle high gives one event, delayed 4 cycles beyond the undebounced latency.

Source files
------------

// File: rtl/in_event_pkg.sv
// ----------------------------------------------------------------------------
// in_event_pkg
// Shared types and constants for the input-event controller.
//   state_e        : offer state machine encoding (IDLE / OFFER)
//   N_DEF          : default number of input channels
//   DEB_CYCLES_DEF : default debounce stability length in cycles
//   id_width()     : width needed to carry a channel number (minimum 1 bit)
// ----------------------------------------------------------------------------
package in_event_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    localparam int N_DEF          = 4;
    localparam int DEB_CYCLES_DEF = 4;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/in_event_ctrl_if.sv
// ----------------------------------------------------------------------------
// in_event_ctrl_if
// Valid/ready event channel from the input-event controller to the CPU
// IN-port logic.
//   ev_valid : an event is offered (driven by master)
//   ev_id    : channel number of the offered event (driven by master)
//   ev_ready : consumer accepts the offered event (driven by slave)
// Modports: master = event producer, slave = event consumer.
// ----------------------------------------------------------------------------
interface in_event_ctrl_if import in_event_pkg::*; #(
    parameter int IDW = id_width(N_DEF)
);

    logic           ev_valid;
    logic           ev_ready;
    logic [IDW-1:0] ev_id;

    modport master (output ev_valid, output ev_id, input ev_ready);
    modport slave  (input ev_valid, input ev_id, output ev_ready);

endinterface

// File: rtl/in_event_ctrl_edge.sv
// ----------------------------------------------------------------------------
// edge_rise_det
// One input channel: optional debounce filter followed by a two-flop
// rising-edge detector.
// Configuration macro: IN_DEBOUNCE_EN
//   defined   : the raw level is filtered; the filtered level only toggles
//               after DEB_CYCLES consecutive cycles of disagreement with it,
//               so shorter pulses are ignored and latency grows by DEB_CYCLES.
//   undefined : the raw level feeds the edge detector directly.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   in_i   : raw input level
//   rise_o : one-cycle rising-edge indication (combinational from registers)
// ----------------------------------------------------------------------------
module edge_rise_det import in_event_pkg::*;
`ifdef IN_DEBOUNCE_EN
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic rise_o
);

    logic level;
    logic s1_q;
    logic s2_q;

`ifdef IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          f_q;
    logic          f_d;

    // The counter only runs while the raw input disagrees with the filtered
    // level; any agreeing cycle restarts the stability window.
    always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        if (in_i != f_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                f_d = ~f_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            f_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            f_q   <= f_d;
        end
    end

    assign level = f_q;
`else
    assign level = in_i;
`endif

    // Both stages clear on reset, so a level already high at reset release
    // produces exactly one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= level;
            s2_q <= s1_q;
        end
    end

    assign rise_o = s1_q & ~s2_q;

endmodule

// File: rtl/in_event_ctrl.sv
// ----------------------------------------------------------------------------
// in_event_ctrl
// Input-event controller: turns N raw level inputs into single rising-edge
// events, keeps one pending flag per channel and serialises the events to the
// CPU as channel IDs on a valid/ready handshake with round-robin arbitration.
// Configuration macro: IN_DEBOUNCE_EN (adds the DEB_CYCLES debounce filter in
// front of every edge detector; DEB_CYCLES exists only in that build).
// Ports:
//   clk           : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   in_i[N]       : raw input levels
//   ev_if         : master side of the event handshake (ev_valid/ev_id/ev_ready)
//   pending_o[N]  : queued events not yet offered
//   overrun_o[N]  : sticky per-channel event-lost flags
//   clr_overrun_i : clears all overrun flags
// ----------------------------------------------------------------------------
module in_event_ctrl import in_event_pkg::*; #(
    parameter int N   = N_DEF,
    parameter int IDW = id_width(N)
`ifdef IN_DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           in_i,
    in_event_ctrl_if.master        ev_if,
    output logic [N-1:0]           pending_o,
    output logic [N-1:0]           overrun_o,
    input  logic                   clr_overrun_i
);

    state_e         state_q;
    logic           ev_valid_q;
    logic [IDW-1:0] ev_id_q;
    logic [IDW-1:0] ptr_q;
    logic [N-1:0]   pending_q;
    logic [N-1:0]   pending_d;
    logic [N-1:0]   overrun_q;
    logic [N-1:0]   overrun_d;

    logic [N-1:0]   rise;
    logic [N-1:0]   grant_mask;
    logic           handshake;
    logic           grant;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;

    // Explicit wrap keeps the pointer inside 0..N-1 for non-power-of-2 N.
    function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
        if (p == IDW'(N - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Per-channel edge detection
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        edge_rise_det
`ifdef IN_DEBOUNCE_EN
        #(
            .DEB_CYCLES (DEB_CYCLES)
        )
`endif
        u_det (
            .clk    (clk),
            .rst_n  (rst_n),
            .in_i   (in_i[gi]),
            .rise_o (rise[gi])
        );
    end

    // ------------------------------------------------------------------
    // Round-robin search: first set pending bit after the pointer
    // ------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = ptr_q;
        for (int k = 0; k < N; k++) begin
            cand = ptr_inc(cand);
            if (!win_found && pending_q[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign handshake = ev_valid_q & ev_if.ev_ready;
    // A new winner can be loaded when nothing is offered or the current
    // offer is being accepted this edge.
    assign grant     = win_found & ((state_q == IDLE) | handshake);

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign grant_mask[gi] = grant & (win_id == IDW'(gi));
    end

    // A fresh edge always (re)sets pending, so an edge on the channel being
    // granted this cycle is kept as a new event. An edge landing on a bit that
    // stays pending means the earlier event is lost.
    assign pending_d = (pending_q & ~grant_mask) | rise;
    assign overrun_d = (clr_overrun_i ? '0 : overrun_q)
                     | (rise & pending_q & ~grant_mask);

    // ------------------------------------------------------------------
    // Offer state machine with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ptr_q      <= IDW'(N - 1);
            pending_q  <= '0;
            overrun_q  <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        ev_valid_q <= 1'b1;
                        ev_id_q    <= win_id;
                        ptr_q      <= win_id;
                        state_q    <= OFFER;
                    end
                end
                OFFER: begin
                    if (handshake) begin
                        if (grant) begin
                            ev_id_q <= win_id;
                            ptr_q   <= win_id;
                        end else begin
                            ev_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: begin
                    ev_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign ev_if.ev_valid = ev_valid_q;
    assign ev_if.ev_id    = ev_id_q;
    assign pending_o      = pending_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_in_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_in_event_ctrl
// Self-checking bench for in_event_ctrl: directed cycle tables, hand-written
// corner sequences and randomized stimulus compared each cycle against a
// behavioural model kept here.
// ----------------------------------------------------------------------------
module tb_in_event_ctrl;
    import in_event_pkg::*;

    localparam int N   = N_DEF;
    localparam int IDW = id_width(N);
`ifdef IN_DEBOUNCE_EN
    localparam int DEB = DEB_CYCLES_DEF;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT = 2 + DEB;       // first-high edge index -> ev_valid
    localparam int HL  = 2 + DEB;       // hold length for the alternation test

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_r  = '0;
    logic         clr_r = 1'b0;
    logic [N-1:0] pending_w;
    logic [N-1:0] overrun_w;

    in_event_ctrl_if #(.IDW(IDW)) ifc();

    in_event_ctrl #(.N(N), .IDW(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_i          (in_r),
        .ev_if         (ifc),
        .pending_o     (pending_w),
        .overrun_o     (overrun_w),
        .clr_overrun_i (clr_r)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int acc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: input history, a pending set, one offer slot and
    // a last-winner pointer searched with modulo arithmetic.
    // ------------------------------------------------------------------
    bit           m_valid;
    int           m_id;
    int           m_ptr;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovr;
    logic [N-1:0] m_h1;     // level seen at the previous edge
    logic [N-1:0] m_h2;     // level seen two edges ago
`ifdef IN_DEBOUNCE_EN
    int           m_cnt[N];
    logic [N-1:0] m_f;
`endif

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_ptr = N - 1;
        m_pend = '0; m_ovr = '0; m_h1 = '0; m_h2 = '0;
`ifdef IN_DEBOUNCE_EN
        m_f = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
    endtask

    task automatic model_update();
        logic [N-1:0] lvl;
        logic [N-1:0] rises;
        logic [N-1:0] old_pend;
        bit           hand;
        int           win;
`ifdef IN_DEBOUNCE_EN
        lvl = m_f;
        for (int i = 0; i < N; i++) begin
            if (in_r[i] != m_f[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == DEB) begin
                    m_f[i]   = ~m_f[i];
                    m_cnt[i] = 0;
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
`else
        lvl = in_r;
`endif
        rises    = m_h1 & ~m_h2;
        m_h2     = m_h1;
        m_h1     = lvl;
        hand     = m_valid && ifc.ev_ready;
        old_pend = m_pend;
        win      = -1;
        if ((!m_valid || hand) && old_pend != '0) begin
            for (int j = 1; j <= N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (win < 0 && old_pend[c]) win = c;
            end
        end
        if (win >= 0) begin
            m_valid = 1; m_id = win; m_ptr = win; m_pend[win] = 1'b0;
        end else if (hand) begin
            m_valid = 0;
        end
        if (clr_r) m_ovr = '0;
        for (int i = 0; i < N; i++) begin
            if (rises[i]) begin
                if (old_pend[i] && i != win) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        check("model_valid", ifc.ev_valid, m_valid);
        if (m_valid) check("model_id", ifc.ev_id, m_id);
        check("model_pending", pending_w, m_pend);
        check("model_overrun", overrun_w, m_ovr);
    endtask

    // One clock cycle: drive at the negedge, model at the posedge, compare at
    // the following negedge.
    task automatic cycle(input logic [N-1:0] i, input logic rdy, input logic clr);
        in_r = i; ifc.ev_ready = rdy; clr_r = clr;
        if (ifc.ev_valid && rdy) begin
            acc_q.push_back(int'(ifc.ev_id));
            $display("event accepted id=%0d t=%0t", ifc.ev_id, $time);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_r = '0; ifc.ev_ready = 1'b0; clr_r = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", ifc.ev_valid, 0);
        check("rst_id", ifc.ev_id, 0);
        check("rst_pending", pending_w, 0);
        check("rst_overrun", overrun_w, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit           rst;
        logic [N-1:0] inp;
        bit           rdy;
        bit           clr;
        bit           exp_v;
        int           exp_id;
        logic [N-1:0] exp_p;
        logic [N-1:0] exp_o;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit rst, logic [N-1:0] i, bit r, bit c,
                               bit ev, int id, logic [N-1:0] p, logic [N-1:0] o);
        vec_t x;
        x.rst = rst; x.inp = i; x.rdy = r; x.clr = c;
        x.exp_v = ev; x.exp_id = id; x.exp_p = p; x.exp_o = o;
        return x;
    endfunction

    initial begin
        logic [N-1:0] lv;
        int           first;
        int           exp_glitch;

        do_reset();

`ifndef IN_DEBOUNCE_EN
        // Single held input: one event two edges after first sample.
        tbl.push_back(v(1, 4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1, 0, 0, 0, 4'b0001, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1, 0, 1, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0001, 1, 0, 0, 0, 4'b0000, 4'b0000));
        // All channels at once: 0,1,2,3 back to back.
        tbl.push_back(v(1, 4'b1111, 1, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 1, 0, 0, 0, 4'b1111, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 1, 0, 1, 0, 4'b1110, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 1, 0, 1, 1, 4'b1100, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 1, 0, 1, 2, 4'b1000, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 1, 0, 1, 3, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b1111, 1, 0, 0, 0, 4'b0000, 4'b0000));
        // Stalled consumer, three ch2 pulses: held offer, pending, overrun.
        tbl.push_back(v(1, 4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 0, 4'b0100, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 0, 0, 1, 2, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0100, 0, 0, 1, 2, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 0, 0, 1, 2, 4'b0100, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 0, 0, 1, 2, 4'b0100, 4'b0000));
        tbl.push_back(v(0, 4'b0100, 0, 0, 1, 2, 4'b0100, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 0, 0, 1, 2, 4'b0100, 4'b0100));
        tbl.push_back(v(0, 4'b0000, 1, 0, 1, 2, 4'b0000, 4'b0100));
        tbl.push_back(v(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0100));
        // Overrun clear racing a new ch3 overrun, then a lone clear.
        tbl.push_back(v(0, 4'b1000, 0, 0, 0, 0, 4'b0000, 4'b0100));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 0, 4'b1000, 4'b0100));
        tbl.push_back(v(0, 4'b0000, 0, 0, 1, 3, 4'b0000, 4'b0100));
        tbl.push_back(v(0, 4'b1000, 0, 0, 1, 3, 4'b0000, 4'b0100));
        tbl.push_back(v(0, 4'b0000, 0, 0, 1, 3, 4'b1000, 4'b0100));
        tbl.push_back(v(0, 4'b1000, 0, 0, 1, 3, 4'b1000, 4'b0100));
        tbl.push_back(v(0, 4'b0000, 0, 1, 1, 3, 4'b1000, 4'b1000));
        tbl.push_back(v(0, 4'b0000, 0, 1, 1, 3, 4'b1000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 1, 0, 1, 3, 4'b0000, 4'b0000));
        tbl.push_back(v(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000));

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            cycle(tbl[k].inp, tbl[k].rdy, tbl[k].clr);
            check($sformatf("row%0d_valid", k), ifc.ev_valid, tbl[k].exp_v);
            if (tbl[k].exp_v) check($sformatf("row%0d_id", k), ifc.ev_id, tbl[k].exp_id);
            check($sformatf("row%0d_pending", k), pending_w, tbl[k].exp_p);
            check($sformatf("row%0d_overrun", k), overrun_w, tbl[k].exp_o);
        end
`endif

        // Two channels rising together repeatedly: grants alternate 0,1,0,1.
        do_reset();
        acc_q.delete();
        for (int p = 0; p < 6; p++) begin
            repeat (HL) cycle(4'b0000, 1'b1, 1'b0);
            repeat (HL) cycle(4'b0011, 1'b1, 1'b0);
        end
        repeat (HL + LAT + 2) cycle(4'b0000, 1'b1, 1'b0);
        check("alt_count", acc_q.size(), 12);
        foreach (acc_q[i]) check($sformatf("alt_id%0d", i), acc_q[i], i % 2);

        // Reset asserted while an event is being offered.
        do_reset();
        for (int k = 0; k < 20 && !ifc.ev_valid; k++) cycle(4'b0010, 1'b0, 1'b0);
        check("offer_reached", ifc.ev_valid, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid", ifc.ev_valid, 0);
        check("async_rst_pending", pending_w, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short glitch (3 cycles), then a 6-cycle pulse with latency check.
        do_reset();
        acc_q.delete();
        repeat (3) cycle(4'b0001, 1'b1, 1'b0);
        repeat (14) cycle(4'b0000, 1'b1, 1'b0);
        exp_glitch = (DEB == 0) ? 1 : 0;
        check("glitch_events", acc_q.size(), exp_glitch);
        acc_q.delete();
        first = -1;
        for (int k = 0; k < 24; k++) begin
            cycle((k < 6) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
            if (first < 0 && ifc.ev_valid) first = k;
        end
        check("pulse_latency", first, LAT);
        check("pulse_events", acc_q.size(), 1);

        // Randomized traffic against the model.
        do_reset();
        lv = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, (DEB == 0) ? 2 : 5) == 0) lv[b] = ~lv[b];
            end
            cycle(lv, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
